// File: rtl/mandel_dispatch.sv
// rtl/mandel_dispatch.sv - raster-order pixel scheduler for a pool of mandelbrot engines
// Optional MANDEL_DISPATCH_STATS_EN adds stat_cycles/stat_stall counters.
module mandel_dispatch #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int FP_WIDTH  = 25,
    parameter int ITERW     = 8,
    parameter int CORES     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FP_WIDTH-1:0]       x_start,
    input  logic [FP_WIDTH-1:0]       y_start,
    input  logic [FP_WIDTH-1:0]       step,
    output logic [CORES-1:0]          core_start,
    output logic [CORES*FP_WIDTH-1:0] core_re,
    output logic [CORES*FP_WIDTH-1:0] core_im,
    input  logic [CORES-1:0]          core_done,
    input  logic [CORES*ITERW-1:0]    core_iter,
    output logic                      px_valid,
    input  logic                      px_ready,
    output logic [CORDW-1:0]          px_x,
    output logic [CORDW-1:0]          px_y,
    output logic [ITERW-1:0]          px_iter,
    output logic                      busy,
    output logic                      done
`ifdef MANDEL_DISPATCH_STATS_EN
    ,
    output logic [31:0]               stat_cycles,
    output logic [31:0]               stat_stall
`endif
);
    localparam int IW = 5;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {E_FREE, E_BUSY, E_HELD} eng_t;

    state_t              state, state_n;
    eng_t                eng    [CORES];
    logic [CORDW-1:0]    tag_x  [CORES];
    logic [CORDW-1:0]    tag_y  [CORES];
    logic [ITERW-1:0]    result [CORES];
    logic [CORDW-1:0]    x, y;
    logic [FP_WIDTH-1:0] fx, fy, xs_r, step_r;
    logic [IW-1:0]       rr_ptr, out_sel, rr_start, scan_idx, free_idx, grant_idx;
    logic                free_found, grant_found, all_free, issue, last_px, hs;
    logic [31:0]         held_mask;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        all_free   = 1'b1;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (eng[i] == E_FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end else begin
                all_free = 1'b0;
            end
        end
    end

    // The engine being handed off this cycle is excluded so the next grant can load on the same edge.
    always_comb begin
        hs        = px_valid && px_ready;
        held_mask = '0;
        for (int i = 0; i < CORES; i++)
            held_mask[i] = (eng[i] == E_HELD) && !(hs && out_sel == IW'(i));
        if (hs)
            rr_start = (out_sel == IW'(CORES - 1)) ? '0 : out_sel + IW'(1);
        else
            rr_start = rr_ptr;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < CORES; k++) begin
            scan_idx = rr_start + IW'(k);
            if (scan_idx >= IW'(CORES))
                scan_idx = scan_idx - IW'(CORES);
            if (!grant_found && held_mask[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        issue   = (state == S_ISSUE) && free_found;
        last_px = (x == CORDW'(FB_WIDTH - 1)) && (y == CORDW'(FB_HEIGHT - 1));
        case (state)
            S_IDLE:  if (start) state_n = S_ISSUE;
            S_ISSUE: if (issue && last_px) state_n = S_DRAIN;
            S_DRAIN: if (all_free && !px_valid) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            core_start <= '0;
            px_valid   <= 1'b0;
            rr_ptr     <= '0;
            out_sel    <= '0;
            for (int i = 0; i < CORES; i++)
                eng[i] <= E_FREE;
        end else begin
            state      <= state_n;
            core_start <= '0;
            if (state == S_IDLE && start) begin
                x      <= '0;
                y      <= '0;
                fx     <= x_start;
                fy     <= y_start;
                xs_r   <= x_start;
                step_r <= step;
            end else if (issue) begin
                if (x == CORDW'(FB_WIDTH - 1)) begin
                    x  <= '0;
                    fx <= xs_r;
                    y  <= y + CORDW'(1);
                    fy <= fy + step_r;
                end else begin
                    x  <= x + CORDW'(1);
                    fx <= fx + step_r;
                end
            end
            for (int i = 0; i < CORES; i++) begin
                case (eng[i])
                    E_FREE: if (issue && free_idx == IW'(i)) begin
                        eng[i]                         <= E_BUSY;
                        tag_x[i]                       <= x;
                        tag_y[i]                       <= y;
                        core_re[i*FP_WIDTH +: FP_WIDTH] <= fx;
                        core_im[i*FP_WIDTH +: FP_WIDTH] <= fy;
                        core_start[i]                  <= 1'b1;
                    end
                    E_BUSY: if (core_done[i]) begin
                        eng[i]    <= E_HELD;
                        result[i] <= core_iter[i*ITERW +: ITERW];
                    end
                    E_HELD: if (hs && out_sel == IW'(i)) eng[i] <= E_FREE;
                    default: eng[i] <= E_FREE;
                endcase
            end
            if (!px_valid || hs) begin
                px_valid <= grant_found;
                for (int i = 0; i < CORES; i++) begin
                    if (grant_found && grant_idx == IW'(i)) begin
                        px_x    <= tag_x[i];
                        px_y    <= tag_y[i];
                        px_iter <= result[i];
                        out_sel <= grant_idx;
                    end
                end
            end
            if (hs)
                rr_ptr <= rr_start;
        end
    end

`ifdef MANDEL_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cycles <= '0;
            stat_stall  <= '0;
        end else if (state == S_IDLE && start) begin
            stat_cycles <= '0;
            stat_stall  <= '0;
        end else begin
            if (busy && stat_cycles != '1)
                stat_cycles <= stat_cycles + 32'd1;
            if (state == S_ISSUE && !free_found && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
